// File: rtl/mc_line_responder.sv
// Memory-controller end of the cache-miss interface: turns 512-bit line fills
// and evictions into 16 word accesses on a word-wide, 1-cycle-latency RAM port.
module mc_line_responder #(
  parameter int LINE_WORDS = 16,
  parameter int MEM_ADDR_W = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cacheMissFetch,
  input  logic [31:0]           pcAddr,
  input  logic                  cacheMissMemory,
  input  logic [31:0]           mcAddr,
  input  logic                  dCacheEvict,
  input  logic [31:0]           evictAddr,
  input  logic [511:0]          dCacheOut,
  input  logic                  fftCalculating,
  output logic                  mcInstrValid,
  output logic [511:0]          mcInstrIn,
  output logic                  mcDataValid,
  output logic [511:0]          mcDataIn,
  output logic                  evictDone,
  output logic [MEM_ADDR_W-1:0] memAddr,
  output logic                  memRe,
  output logic                  memWe,
  output logic [31:0]           memWdata,
  input  logic [31:0]           memRdata
);

  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int LA_W   = MEM_ADDR_W - 4;

  typedef enum logic [2:0] {IDLE, EVICT, FILL_D, FILL_I, RESP, COOL} state_t;

  state_t                state_q;
  logic [4:0]            cnt_q;
  logic [LA_W-1:0]       lineAddr_q;
  logic [LINE_W-1:0]     lineBuf_q;
  logic [LINE_W-1:0]     instrLine_q;
  logic [LINE_W-1:0]     dataLine_q;
  logic [MEM_ADDR_W-1:0] memAddr_q;
  logic                  memRe_q;
  logic                  memWe_q;
  logic [31:0]           memWdata_q;
  logic                  instrValid_q;
  logic                  dataValid_q;
  logic                  evictDone_q;

  logic [3:0]            capIdx_d;
  logic [3:0]            nextIdx_d;
  logic [LINE_W-1:0]     fillLine_d;
  logic                  unusedAddrBits;

  // Read data arrives one cycle after its strobe, so the captured word trails the counter by one.
  assign capIdx_d  = cnt_q[3:0] - 4'd1;
  assign nextIdx_d = cnt_q[3:0] + 4'd1;

  always_comb begin
    fillLine_d = lineBuf_q;
    fillLine_d[32*int'(capIdx_d) +: 32] = memRdata;
  end

  assign unusedAddrBits = ^{pcAddr[31:MEM_ADDR_W], pcAddr[3:0],
                            mcAddr[31:MEM_ADDR_W], mcAddr[3:0],
                            evictAddr[31:MEM_ADDR_W], evictAddr[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lineAddr_q   <= '0;
      lineBuf_q    <= '0;
      instrLine_q  <= '0;
      dataLine_q   <= '0;
      memAddr_q    <= '0;
      memRe_q      <= 1'b0;
      memWe_q      <= 1'b0;
      memWdata_q   <= '0;
      instrValid_q <= 1'b0;
      dataValid_q  <= 1'b0;
      evictDone_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fftCalculating) begin
            cnt_q <= '0;
            if (dCacheEvict) begin
              state_q    <= EVICT;
              lineAddr_q <= evictAddr[MEM_ADDR_W-1:4];
              lineBuf_q  <= dCacheOut;
              memAddr_q  <= {evictAddr[MEM_ADDR_W-1:4], 4'd0};
              memWdata_q <= dCacheOut[31:0];
              memWe_q    <= 1'b1;
            end else if (cacheMissMemory) begin
              state_q    <= FILL_D;
              lineAddr_q <= mcAddr[MEM_ADDR_W-1:4];
              memAddr_q  <= {mcAddr[MEM_ADDR_W-1:4], 4'd0};
              memRe_q    <= 1'b1;
            end else if (cacheMissFetch) begin
              state_q    <= FILL_I;
              lineAddr_q <= pcAddr[MEM_ADDR_W-1:4];
              memAddr_q  <= {pcAddr[MEM_ADDR_W-1:4], 4'd0};
              memRe_q    <= 1'b1;
            end
          end
        end
        EVICT: begin
          if (cnt_q < 5'(LINE_WORDS - 1)) begin
            cnt_q      <= cnt_q + 5'd1;
            memAddr_q  <= {lineAddr_q, nextIdx_d};
            memWdata_q <= lineBuf_q[32*int'(nextIdx_d) +: 32];
          end else if (cnt_q == 5'(LINE_WORDS - 1)) begin
            cnt_q       <= cnt_q + 5'd1;
            memWe_q     <= 1'b0;
            evictDone_q <= 1'b1;
          end else begin
            evictDone_q <= 1'b0;
            state_q     <= COOL;
          end
        end
        FILL_D, FILL_I: begin
          if (cnt_q != 5'd0) begin
            lineBuf_q <= fillLine_d;
          end
          if (cnt_q < 5'(LINE_WORDS - 1)) begin
            memAddr_q <= {lineAddr_q, nextIdx_d};
          end else if (cnt_q == 5'(LINE_WORDS - 1)) begin
            memRe_q <= 1'b0;
          end
          // The last word lands on this edge, so the response line is taken from the merged buffer.
          if (cnt_q == 5'(LINE_WORDS)) begin
            state_q <= RESP;
            if (state_q == FILL_D) begin
              dataLine_q  <= fillLine_d;
              dataValid_q <= 1'b1;
            end else begin
              instrLine_q  <= fillLine_d;
              instrValid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        RESP: begin
          dataValid_q  <= 1'b0;
          instrValid_q <= 1'b0;
          state_q      <= COOL;
        end
        COOL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mcInstrValid = instrValid_q;
  assign mcInstrIn    = instrLine_q;
  assign mcDataValid  = dataValid_q;
  assign mcDataIn     = dataLine_q;
  assign evictDone    = evictDone_q;
  assign memAddr      = memAddr_q;
  assign memRe        = memRe_q;
  assign memWe        = memWe_q;
  assign memWdata     = memWdata_q;

endmodule
